rc4_prga_decryptor: RTL and testbench



---
 rtl/rc4_prga_decryptor_pkg.sv | 28 ++
 rtl/rc4_prga_decryptor_if.sv | 30 +++
 rtl/rc4_prga_decryptor_trap_edge.sv | 22 ++
 rtl/rc4_prga_decryptor.sv | 183 ++++++++++++++++++
 tb/tb_rc4_prga_decryptor.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rc4_prga_decryptor_pkg.sv
// Shared types and constants for the RC4 PRGA decryptor.
package rc4_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_I,
        ST_WAIT_I,
        ST_GET_I,
        ST_WAIT_J,
        ST_GET_J,
        ST_WR_J,
        ST_RD_F,
        ST_WAIT_F,
        ST_GET_F,
        ST_WR_DEC,
        ST_NEXT
    } prga_state_t;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LO_A  = 8'h61;
    localparam logic [7:0] CHAR_LO_Z  = 8'h7A;

    function automatic logic is_text(input logic [7:0] b);
        return (b == CHAR_SPACE) ||
               ((b >= CHAR_LO_A) && (b <= CHAR_LO_Z));
    endfunction

endpackage

// File: rtl/rc4_prga_decryptor_if.sv
// Memory-side bus of the decryptor: S RAM, encrypted ROM, result RAM.
interface rc4_prga_decryptor_if #(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int MSG_ADDR_WIDTH = 5
);
    logic [RAM_WIDTH-1:0]      ram_out;
    logic [RAM_LENGTH-1:0]     address;
    logic [RAM_WIDTH-1:0]      ram_in;
    logic                      write_enable;
    logic [MSG_ADDR_WIDTH-1:0] enc_address;
    logic [RAM_WIDTH-1:0]      enc_out;
    logic [MSG_ADDR_WIDTH-1:0] dec_address;
    logic [RAM_WIDTH-1:0]      dec_in;
    logic                      dec_write_enable;

    modport master (
        input  ram_out, enc_out,
        output address, ram_in, write_enable,
        output enc_address, dec_address, dec_in,
        output dec_write_enable
    );

    modport slave (
        output ram_out, enc_out,
        input  address, ram_in, write_enable,
        input  enc_address, dec_address, dec_in,
        input  dec_write_enable
    );
endinterface

// File: rtl/rc4_prga_decryptor_trap_edge.sv
// Registered rising-edge detector; edge_o is a one-cycle pulse.
module trap_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic level_i,
    output logic edge_o
);
    logic level_q;
    logic edge_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            level_q <= level_i;
            edge_q  <= level_i & ~level_q;
        end
    end

    assign edge_o = edge_q;
endmodule

// File: rtl/rc4_prga_decryptor.sv
// RC4 PRGA: walks the S-box, XORs the keystream with the message ROM and
// writes plaintext to the result RAM, optionally aborting on non-text bytes.
module rc4_prga_decryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_LENGTH     = 8,
    parameter int MSG_LENGTH     = 32,
    parameter int MSG_ADDR_WIDTH = 5,
    parameter int CHECK_TEXT     = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    output logic finished,
    output logic invalid,
    rc4_prga_decryptor_if.master mem
);
    localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST =
        MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

    prga_state_t state_q, state_d;

    logic [RAM_LENGTH-1:0]     i_q, i_d;
    logic [RAM_LENGTH-1:0]     j_q, j_d;
    logic [MSG_ADDR_WIDTH-1:0] k_q, k_d;
    logic [RAM_WIDTH-1:0]      si_q, si_d;
    logic [RAM_WIDTH-1:0]      sj_q, sj_d;

    logic [RAM_LENGTH-1:0]     address_q, address_d;
    logic [RAM_WIDTH-1:0]      ram_in_q, ram_in_d;
    logic                      we_q, we_d;
    logic [MSG_ADDR_WIDTH-1:0] enc_addr_q, enc_addr_d;
    logic [MSG_ADDR_WIDTH-1:0] dec_addr_q, dec_addr_d;
    logic [RAM_WIDTH-1:0]      dec_in_q, dec_in_d;
    logic                      dec_we_q, dec_we_d;
    logic                      finished_q, finished_d;
    logic                      invalid_q, invalid_d;

    logic start_edge;

    trap_edge u_trap_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level_i (start),
        .edge_o  (start_edge)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            si_q       <= '0;
            sj_q       <= '0;
            address_q  <= '0;
            ram_in_q   <= '0;
            we_q       <= 1'b0;
            enc_addr_q <= '0;
            dec_addr_q <= '0;
            dec_in_q   <= '0;
            dec_we_q   <= 1'b0;
            finished_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            address_q  <= address_d;
            ram_in_q   <= ram_in_d;
            we_q       <= we_d;
            enc_addr_q <= enc_addr_d;
            dec_addr_q <= dec_addr_d;
            dec_in_q   <= dec_in_d;
            dec_we_q   <= dec_we_d;
            finished_q <= finished_d;
            invalid_q  <= invalid_d;
        end
    end

    // Each state's registered outputs are set on the edge leaving it, so
    // the memories see them during the following state.
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        si_d       = si_q;
        sj_d       = sj_q;
        address_d  = address_q;
        ram_in_d   = ram_in_q;
        we_d       = 1'b0;
        enc_addr_d = enc_addr_q;
        dec_addr_d = dec_addr_q;
        dec_in_d   = dec_in_q;
        dec_we_d   = 1'b0;
        finished_d = 1'b0;
        invalid_d  = invalid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    invalid_d = 1'b0;
                    state_d   = ST_RD_I;
                end
            end
            ST_RD_I: begin
                i_d       = i_q + 1'b1;
                address_d = i_q + 1'b1;
                state_d   = ST_WAIT_I;
            end
            ST_WAIT_I: state_d = ST_GET_I;
            ST_GET_I: begin
                si_d      = mem.ram_out;
                j_d       = j_q + RAM_LENGTH'(mem.ram_out);
                address_d = j_q + RAM_LENGTH'(mem.ram_out);
                state_d   = ST_WAIT_J;
            end
            ST_WAIT_J: state_d = ST_GET_J;
            ST_GET_J: begin
                sj_d      = mem.ram_out;
                address_d = i_q;
                ram_in_d  = mem.ram_out;
                we_d      = 1'b1;
                state_d   = ST_WR_J;
            end
            ST_WR_J: begin
                address_d = j_q;
                ram_in_d  = si_q;
                we_d      = 1'b1;
                state_d   = ST_RD_F;
            end
            ST_RD_F: begin
                address_d  = RAM_LENGTH'(si_q) + RAM_LENGTH'(sj_q);
                enc_addr_d = k_q;
                state_d    = ST_WAIT_F;
            end
            ST_WAIT_F: state_d = ST_GET_F;
            ST_GET_F: begin
                dec_in_d   = mem.ram_out ^ mem.enc_out;
                dec_addr_d = k_q;
                state_d    = ST_WR_DEC;
            end
            ST_WR_DEC: begin
                dec_we_d = 1'b1;
                if ((CHECK_TEXT != 0) && !is_text(8'(dec_in_q))) begin
                    finished_d = 1'b1;
                    invalid_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (k_q < K_LAST) begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_RD_I;
                end else begin
                    finished_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign finished             = finished_q;
    assign invalid              = invalid_q;
    assign mem.address          = address_q;
    assign mem.ram_in           = ram_in_q;
    assign mem.write_enable     = we_q;
    assign mem.enc_address      = enc_addr_q;
    assign mem.dec_address      = dec_addr_q;
    assign mem.dec_in           = dec_in_q;
    assign mem.dec_write_enable = dec_we_q;
endmodule

// File: tb/tb_rc4_prga_decryptor.sv
// Bench: two decryptors (text check off/on) with behavioural memories,
// checked against a plain RC4 reference model.
module tb_rc4_prga_decryptor;
    localparam int L  = 300;
    localparam int AW = 9;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] start;
    logic [1:0] fin;
    logic [1:0] inv;

    always #5 clk = ~clk;

    rc4_prga_decryptor_if #(.RAM_WIDTH(8), .RAM_LENGTH(8),
        .MSG_ADDR_WIDTH(AW)) m0 ();
    rc4_prga_decryptor_if #(.RAM_WIDTH(8), .RAM_LENGTH(8),
        .MSG_ADDR_WIDTH(AW)) m1 ();

    rc4_prga_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(L),
        .MSG_ADDR_WIDTH(AW), .CHECK_TEXT(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]),
        .finished(fin[0]), .invalid(inv[0]), .mem(m0));

    rc4_prga_decryptor #(.RAM_WIDTH(8), .RAM_LENGTH(8), .MSG_LENGTH(L),
        .MSG_ADDR_WIDTH(AW), .CHECK_TEXT(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]),
        .finished(fin[1]), .invalid(inv[1]), .mem(m1));

    logic [7:0] img [256];
    logic [7:0] s0 [256];
    logic [7:0] s1 [256];
    logic [7:0] enc0 [512];
    logic [7:0] enc1 [512];
    logic [7:0] dec0 [512];
    logic [7:0] dec1 [512];
    logic [7:0] s0_rd, s1_rd, e0_rd, e1_rd;
    logic       load0, load1;
    int ndec0 = 0, ndec1 = 0, nfin0 = 0, nfin1 = 0;

    always @(posedge clk) begin
        if (load0) s0 <= img;
        else if (m0.write_enable) s0[m0.address] <= m0.ram_in;
        s0_rd <= s0[m0.address];
        e0_rd <= enc0[m0.enc_address];
        if (m0.dec_write_enable) begin
            dec0[m0.dec_address] <= m0.dec_in;
            ndec0 <= ndec0 + 1;
        end
        if (fin[0]) nfin0 <= nfin0 + 1;
    end

    always @(posedge clk) begin
        if (load1) s1 <= img;
        else if (m1.write_enable) s1[m1.address] <= m1.ram_in;
        s1_rd <= s1[m1.address];
        e1_rd <= enc1[m1.enc_address];
        if (m1.dec_write_enable) begin
            dec1[m1.dec_address] <= m1.dec_in;
            ndec1 <= ndec1 + 1;
        end
        if (fin[1]) nfin1 <= nfin1 + 1;
    end

    assign m0.ram_out = s0_rd;
    assign m0.enc_out = e0_rd;
    assign m1.ram_out = s1_rd;
    assign m1.enc_out = e1_rd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] out_vec(input int d);
        if (d == 0)
            return {18'd0, fin[0], inv[0], m0.address, m0.ram_in,
                    m0.write_enable, m0.enc_address, m0.dec_address,
                    m0.dec_in, m0.dec_write_enable};
        return {18'd0, fin[1], inv[1], m1.address, m1.ram_in,
                m1.write_enable, m1.enc_address, m1.dec_address,
                m1.dec_in, m1.dec_write_enable};
    endfunction

    // Reference model: textbook RC4 on plain arrays.
    logic [7:0] ms [256];
    logic [7:0] mks [L];

    task automatic set_identity();
        for (int x = 0; x < 256; x++) img[x] = 8'(x);
        ms = img;
    endtask

    task automatic set_key();
        logic [7:0] key [3];
        logic [7:0] t;
        int j;
        key = '{8'h4B, 8'h65, 8'h79};
        for (int x = 0; x < 256; x++) img[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + int'(img[x]) + int'(key[x % 3])) % 256;
            t = img[x]; img[x] = img[j]; img[j] = t;
        end
        ms = img;
    endtask

    task automatic model_prga();
        int i, j, si, sj;
        i = 0; j = 0;
        for (int k = 0; k < L; k++) begin
            i = (i + 1) % 256;
            si = int'(ms[i]);
            j = (j + si) % 256;
            sj = int'(ms[j]);
            ms[i] = 8'(sj);
            ms[j] = 8'(si);
            mks[k] = ms[(si + sj) % 256];
        end
    endtask

    task automatic fill_enc(input int d);
        for (int k = 0; k < 512; k++) begin
            if (d == 0) enc0[k] = 8'($urandom_range(0, 255));
            else        enc1[k] = 8'($urandom_range(0, 255));
        end
    endtask

    function automatic int dec_bad(input int d, input int n);
        int b = 0;
        for (int k = 0; k < n; k++) begin
            if (d == 0 && dec0[k] !== (mks[k] ^ enc0[k])) b++;
            if (d == 1 && dec1[k] !== (mks[k] ^ enc1[k])) b++;
        end
        return b;
    endfunction

    task automatic load(input int d);
        if (d == 0) load0 = 1'b1;
        else        load1 = 1'b1;
        @(posedge clk); #1;
        load0 = 1'b0;
        load1 = 1'b0;
    endtask

    // fin_at counts edges from the first edge that samples start high.
    task automatic run(input int d, input bit toggle,
                       output int fin_at, output int writes);
        int nd, nf;
        nd = (d == 0) ? ndec0 : ndec1;
        nf = (d == 0) ? nfin0 : nfin1;
        load(d);
        start[d] = 1'b1;
        fin_at = -1;
        for (int c = 0; c <= 11 * L + 20; c++) begin
            @(posedge clk); #1;
            if (toggle && c >= 50 && c < 60) start[d] = ~start[d];
            if (fin_at >= 0) begin
                chk("fin_width", 64'(fin[d]), 64'd0);
                break;
            end
            if (fin[d]) fin_at = c;
        end
        if (fin_at < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: dut%0d got no finished, want one", d);
        end
        start[d] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        writes = ((d == 0) ? ndec0 : ndec1) - nd;
        chk("fin_count", 64'(((d == 0) ? nfin0 : nfin1) - nf), 64'd1);
    endtask

    typedef struct {
        logic [7:0] ch;
        bit         bad;
    } vec_t;

    initial begin
        vec_t       tv [7];
        logic [7:0] pl [9];
        logic [7:0] ct [9];
        logic [7:0] pt [L];
        int fa, wr, b, r;

        tv[0] = '{8'h1F, 1'b1};
        tv[1] = '{8'h20, 1'b0};
        tv[2] = '{8'h21, 1'b1};
        tv[3] = '{8'h61, 1'b0};
        tv[4] = '{8'h60, 1'b1};
        tv[5] = '{8'h7A, 1'b0};
        tv[6] = '{8'h7B, 1'b1};
        pl = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
        ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

        reset_n = 1'b0;
        start   = 2'b00;
        load0   = 1'b0;
        load1   = 1'b0;
        set_identity();
        fill_enc(0);
        fill_enc(1);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out0", out_vec(0), 64'd0);
        chk("reset_out1", out_vec(1), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Identity S, start toggled mid-run
        set_identity();
        model_prga();
        fill_enc(0);
        enc0[0] = 8'h63; enc0[1] = 8'h67; enc0[2] = 8'h64;
        run(0, 1'b1, fa, wr);
        chk("id_fin_at", 64'(fa), 64'(11 * L + 1));
        chk("id_invalid", 64'(inv[0]), 64'd0);
        chk("id_writes", 64'(wr), 64'(L));
        chk("id_dec012", {40'd0, dec0[0], dec0[1], dec0[2]}, 64'h616263);
        chk("id_dec_model", 64'(dec_bad(0, L)), 64'd0);
        b = 0;
        for (int x = 0; x < 256; x++) if (s0[x] !== ms[x]) b++;
        chk("id_final_s", 64'(b), 64'd0);

        // Key "Key", text check off
        set_key();
        model_prga();
        fill_enc(0);
        for (int k = 0; k < 9; k++) enc0[k] = ct[k];
        run(0, 1'b0, fa, wr);
        b = 0;
        for (int k = 0; k < 9; k++) if (dec0[k] !== pl[k]) b++;
        chk("key_plaintext", 64'(b), 64'd0);
        chk("key_dec_model", 64'(dec_bad(0, L)), 64'd0);
        chk("key_invalid", 64'(inv[0]), 64'd0);

        // Key "Key", text check on: 'P' aborts at k = 0
        for (int k = 0; k < 512; k++) enc1[k] = enc0[k];
        run(1, 1'b0, fa, wr);
        chk("abort_fin_at", 64'(fa), 64'd11);
        chk("abort_invalid", 64'(inv[1]), 64'd1);
        chk("abort_writes", 64'(wr), 64'd1);
        chk("abort_dec0", 64'(dec1[0]), 64'h50);

        // Character-class boundaries at k = 2
        set_identity();
        model_prga();
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < L; k++) begin
                r = $urandom_range(0, 26);
                pt[k] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
            end
            pt[2] = tv[t].ch;
            for (int k = 0; k < L; k++) enc1[k] = pt[k] ^ mks[k];
            run(1, 1'b0, fa, wr);
            chk($sformatf("tc%0h_invalid", tv[t].ch), 64'(inv[1]),
                64'(tv[t].bad));
            if (tv[t].bad) begin
                chk($sformatf("tc%0h_fin_at", tv[t].ch), 64'(fa), 64'd33);
                chk($sformatf("tc%0h_writes", tv[t].ch), 64'(wr), 64'd3);
                chk($sformatf("tc%0h_dec2", tv[t].ch), 64'(dec1[2]),
                    64'(tv[t].ch));
            end else begin
                chk($sformatf("tc%0h_fin_at", tv[t].ch), 64'(fa),
                    64'(11 * L + 1));
                b = 0;
                for (int k = 0; k < L; k++) if (dec1[k] !== pt[k]) b++;
                chk($sformatf("tc%0h_dec", tv[t].ch), 64'(b), 64'd0);
            end
        end

        // Reset during WR_J of k = 1 (i = 2, j = 3)
        set_identity();
        load(0);
        start[0] = 1'b1;
        repeat (18) @(posedge clk);
        #1;
        chk("wrj_strobe", {47'd0, m0.write_enable, m0.address, m0.ram_in},
            {47'd0, 1'b1, 8'd2, 8'd3});
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out", out_vec(0), 64'd0);
        start[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_s23", {48'd0, s0[2], s0[3]}, 64'h0203);
        reset_n = 1'b1;
        @(posedge clk); #1;
        set_identity();
        model_prga();
        fill_enc(0);
        run(0, 1'b0, fa, wr);
        chk("rerun_fin_at", 64'(fa), 64'(11 * L + 1));
        chk("rerun_writes", 64'(wr), 64'(L));
        chk("rerun_dec_model", 64'(dec_bad(0, L)), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
